multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle control FSM that sequences the CPU datapath (program counter, simple memory, instruction register, register file and ALU) through fetch, decode, execute and writeback. It drives the datapath enables and the ALU operation, and handles the fetch handshake with memory. It decodes the R-type ALU subset and halts on SYSTEM or illegal encodings. It replaces the current free-running PC and always-latching IR with explicit, stallable sequencing.

## Interface
- XLEN, 32, datapath/instruction width
- FETCH_TIMEOUT, 16, max cycles in FETCH awaiting mem_ready (used only with macro)

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  permits leaving IDLE and starting the next instruction
- instruction  in  XLEN  current IR contents
- mem_ready  in  1  memory data valid for current PC
- mem_req  out  1  fetch request to memory
- ir_we  out  1  IR load enable
- pc_en  out  1  PC advance (+4) enable
- reg_we  out  1  register file write enable
- alu_op  out  3  ALU operation (alu_op_t)
- halted  out  1  sticky, FSM in HALT
- illegal  out  1  sticky, halt caused by undecodable instruction
- timeout  out  1  sticky, halt caused by fetch timeout (0 when macro off)
- instr_count  out  32  retired instruction counter
- state  out  3  current state_t, for debug

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE: go to FETCH when run=1, else hold.
- FETCH: mem_req=1. When mem_ready=1, ir_we=1 in the same cycle (Mealy), then go to DECODE. Otherwise hold.
- DECODE: classify `instruction` and register the alu_op.
  - opcode 0110011 with funct3/funct7: 000/0000000 ADD, 000/0100000 SUB, 111/0 AND, 110/0 OR, 100/0 XOR. Next state EXECUTE.
  - opcode 1110011 → HALT, illegal=0.
  - Any other encoding, including all-zeros → HALT, illegal=1.
- EXECUTE: alu_op stays stable; the ALU result settles. Go to WRITEBACK.
- WRITEBACK: pc_en=1 for exactly one cycle. reg_we=1 only if rd (instruction[11:7]) != 0. instr_count +1, wrapping at 2^32. Next state FETCH if run=1, else IDLE.
- HALT: absorbing, left only by reset. All enables are 0.
- alu_op holds its last decoded value outside DECODE. Encodings: ADD=0, SUB=1, AND=2, OR=3, XOR=4.

## Timing
- Reset (async assert, sync release) sets state=IDLE. All outputs are 0, including instr_count, alu_op=ADD and the sticky flags.
- Reset mid-instruction takes effect immediately: outputs drop in the same cycle, with no partial writeback.
- Minimum 4 cycles per instruction: FETCH (mem_ready already high), DECODE, EXECUTE, WRITEBACK. Each wait cycle in FETCH adds one.
- ir_we and pc_en never assert in the same cycle. reg_we and pc_en coincide in WRITEBACK.
- run deasserting mid-instruction does not abort; the instruction completes and the FSM then parks in IDLE.
- instruction must be stable from DECODE through WRITEBACK; the IR is loaded only on ir_we.
- mem_ready outside FETCH is ignored.

## Configuration
- CTRL_FETCH_TIMEOUT_EN defined: a cycle counter starts on FETCH entry.
  - If mem_ready has not arrived after FETCH_TIMEOUT cycles in FETCH, the FSM goes to HALT with timeout=1.
  - mem_ready arriving in the final counted cycle is still accepted.
- Not defined: FETCH waits indefinitely. timeout is tied to 0 and the counter is not synthesised.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - state_t and alu_op_t enums.
  - Opcode constants OP_RTYPE and OP_SYSTEM.
  - funct3/funct7 constants.
- Sub-module instruction_decoder (combinational): instruction → {valid, is_system, alu_op, rd_nonzero}. The controller instantiates it once.

## Test plan
- Happy path: reset low for 2 cycles, then run=1 with mem_ready tied 1. Memory holds three ADD x1,x2,x3 (0x003100B3). Required: 4-cycle cadence, pc_en pulses at cycles 4/8/12, reg_we with each, instr_count=3.
- Fetch stall: mem_ready low for 5 cycles after FETCH entry. Required: mem_req held, no ir_we, and ir_we in the cycle mem_ready rises.
- rd=x0: ADD x0,x1,x2 (0x00208033). Required: pc_en=1, reg_we=0 in WRITEBACK, count increments.
- Illegal/system: all-zeros instruction → HALT with illegal=1. 0x00100073 (ebreak) → HALT with illegal=0. Both stay halted with run=1.
- Async reset during EXECUTE, applied mid-cycle. Required: all outputs 0 before the next edge, state=IDLE.
- With CTRL_FETCH_TIMEOUT_EN and FETCH_TIMEOUT=16, mem_ready never asserted. Required: HALT and timeout=1 after 16 FETCH cycles. mem_ready on cycle 16 is accepted normally.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared types and constants for the multi-cycle CPU controller.
//   state_t  : controller FSM states (also exported on the debug port)
//   alu_op_t : ALU operation select driven to the datapath
//   dec_t    : bundle produced by instruction_decoder
//   OP_* / F3_* / F7_* : opcode and function-field encodings of the
//                        supported R-type ALU subset and SYSTEM
// ----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_XOR     = 3'b100;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic    valid;       // supported R-type ALU instruction
    logic    is_system;   // SYSTEM opcode: orderly halt, not an error
    alu_op_t alu_op;      // meaningful only when valid
    logic    rd_nonzero;  // destination is not x0
  } dec_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// ----------------------------------------------------------------------------
// multicycle_controller_if
// Control bundle between the multi-cycle controller and the CPU datapath.
//   master : controller side (consumes run/instruction/mem_ready, drives the
//            enables, alu_op, sticky status flags, retire count and state)
//   slave  : datapath / environment side (mirror image)
// Parameter XLEN: instruction width.
// ----------------------------------------------------------------------------
interface multicycle_controller_if #(
  parameter int XLEN = 32
) ();
  import cpu_ctrl_pkg::*;

  logic            run;
  logic [XLEN-1:0] instruction;
  logic            mem_ready;
  logic            mem_req;
  logic            ir_we;
  logic            pc_en;
  logic            reg_we;
  alu_op_t         alu_op;
  logic            halted;
  logic            illegal;
  logic            timeout;
  logic [31:0]     instr_count;
  state_t          state;

  modport master (
    input  run, instruction, mem_ready,
    output mem_req, ir_we, pc_en, reg_we, alu_op,
           halted, illegal, timeout, instr_count, state
  );

  modport slave (
    output run, instruction, mem_ready,
    input  mem_req, ir_we, pc_en, reg_we, alu_op,
           halted, illegal, timeout, instr_count, state
  );

endinterface

// File: rtl/multicycle_controller_decoder.sv
// ----------------------------------------------------------------------------
// instruction_decoder
// Purely combinational classifier for the IR contents.
//   i_instr : current instruction register value (XLEN bits)
//   o_dec   : {valid, is_system, alu_op, rd_nonzero}
// Anything that is neither a supported R-type ALU op nor SYSTEM comes out
// with valid=0 and is_system=0, which the controller treats as illegal.
// ----------------------------------------------------------------------------
module instruction_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_instr,
  output dec_t            o_dec
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_unused_fields;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  // Register source fields do not affect control.
  assign w_unused_fields = ^i_instr[24:15];

  // Classify the instruction and select the ALU operation.
  always_comb begin
    o_dec            = '0;
    o_dec.alu_op     = ALU_ADD;
    o_dec.rd_nonzero = |i_instr[11:7];
    if (w_opcode == OP_RTYPE) begin
      case ({w_funct7, w_funct3})
        {F7_BASE, F3_ADD_SUB}: begin o_dec.valid = 1'b1; o_dec.alu_op = ALU_ADD; end
        {F7_ALT,  F3_ADD_SUB}: begin o_dec.valid = 1'b1; o_dec.alu_op = ALU_SUB; end
        {F7_BASE, F3_AND}:     begin o_dec.valid = 1'b1; o_dec.alu_op = ALU_AND; end
        {F7_BASE, F3_OR}:      begin o_dec.valid = 1'b1; o_dec.alu_op = ALU_OR;  end
        {F7_BASE, F3_XOR}:     begin o_dec.valid = 1'b1; o_dec.alu_op = ALU_XOR; end
        default:               begin o_dec.valid = 1'b0; o_dec.alu_op = ALU_ADD; end
      endcase
    end else if (w_opcode == OP_SYSTEM) begin
      o_dec.is_system = 1'b1;
    end else begin
      o_dec.valid     = 1'b0;
      o_dec.is_system = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
// Sequences the CPU datapath through FETCH / DECODE / EXECUTE / WRITEBACK,
// with an IDLE park state gated by run and an absorbing HALT state.
// Ports:
//   clock   : system clock, rising edge
//   reset   : asynchronous active-low reset
//   ctrl_if : multicycle_controller_if.master (run, instruction, mem_ready in;
//             mem_req, ir_we, pc_en, reg_we, alu_op, halted, illegal,
//             timeout, instr_count, state out)
// Parameters: XLEN (instruction width), FETCH_TIMEOUT (fetch wait limit).
// Build option: define CTRL_FETCH_TIMEOUT_EN to halt with timeout=1 when
// mem_ready has not arrived within FETCH_TIMEOUT cycles of FETCH entry.
// Without it FETCH waits forever and timeout stays 0.
// ----------------------------------------------------------------------------
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  multicycle_controller_if.master       ctrl_if
);

  state_t      r_state;
  alu_op_t     r_alu_op;
  logic        r_mem_req;
  logic        r_pc_en;
  logic        r_reg_we;
  logic        r_halted;
  logic        r_illegal;
  logic        r_timeout;
  logic [31:0] r_instr_count;
  dec_t        w_dec;
  logic        w_fetch_expired;

  instruction_decoder #(
    .XLEN (XLEN)
  ) u_decoder (
    .i_instr (ctrl_if.instruction),
    .o_dec   (w_dec)
  );

`ifdef CTRL_FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
  logic [CNT_W-1:0] r_fetch_cnt;

  // The last counted FETCH cycle: still accepts mem_ready, otherwise halts.
  assign w_fetch_expired = (r_fetch_cnt == CNT_W'(FETCH_TIMEOUT - 1));

  // Count FETCH cycles spent waiting; any other state re-arms the counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetch_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == S_FETCH) && !ctrl_if.mem_ready) begin
      r_fetch_cnt <= r_fetch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_fetch_cnt <= {CNT_W{1'b0}};
    end
  end
`else
  logic w_unused_timeout_cfg;
  assign w_fetch_expired      = 1'b0;
  assign w_unused_timeout_cfg = (FETCH_TIMEOUT > 0);
`endif

  // Controller FSM: next state plus all registered control outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_alu_op      <= ALU_ADD;
      r_mem_req     <= 1'b0;
      r_pc_en       <= 1'b0;
      r_reg_we      <= 1'b0;
      r_halted      <= 1'b0;
      r_illegal     <= 1'b0;
      r_timeout     <= 1'b0;
      r_instr_count <= 32'd0;
    end else begin
      // Writeback strobes are single-cycle pulses.
      r_pc_en  <= 1'b0;
      r_reg_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ctrl_if.run) begin
            r_state   <= S_FETCH;
            r_mem_req <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FETCH: begin
          if (ctrl_if.mem_ready) begin
            r_state   <= S_DECODE;
            r_mem_req <= 1'b0;
          end else if (w_fetch_expired) begin
            r_state   <= S_HALT;
            r_mem_req <= 1'b0;
            r_halted  <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_DECODE: begin
          if (w_dec.valid) begin
            r_state  <= S_EXECUTE;
            r_alu_op <= w_dec.alu_op;
          end else begin
            // SYSTEM halts cleanly; every other undecodable word is illegal.
            r_state   <= S_HALT;
            r_halted  <= 1'b1;
            r_illegal <= ~w_dec.is_system;
          end
        end
        S_EXECUTE: begin
          r_state  <= S_WRITEBACK;
          r_pc_en  <= 1'b1;
          r_reg_we <= w_dec.rd_nonzero;
        end
        S_WRITEBACK: begin
          r_instr_count <= r_instr_count + 32'd1;
          if (ctrl_if.run) begin
            r_state   <= S_FETCH;
            r_mem_req <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // ir_we is Mealy so the IR captures memory data in the cycle it is valid.
  assign ctrl_if.ir_we       = (r_state == S_FETCH) & ctrl_if.mem_ready;
  assign ctrl_if.mem_req     = r_mem_req;
  assign ctrl_if.pc_en       = r_pc_en;
  assign ctrl_if.reg_we      = r_reg_we;
  assign ctrl_if.alu_op      = r_alu_op;
  assign ctrl_if.halted      = r_halted;
  assign ctrl_if.illegal     = r_illegal;
  assign ctrl_if.timeout     = r_timeout;
  assign ctrl_if.instr_count = r_instr_count;
  assign ctrl_if.state       = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// ----------------------------------------------------------------------------
// tb_multicycle_controller
// Cycle-by-cycle bench for multicycle_controller. The expected behaviour of
// each instruction is derived from its class (ALU op / SYSTEM / illegal,
// found with RISC-V mask/match patterns) and the fetch wait count; the
// bench then walks the expected phase sequence and compares every output.
// ----------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2;
  localparam int ST_EXECUTE = 3, ST_WB = 4, ST_HALT = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;

  multicycle_controller_if #(.XLEN(32)) ifc ();

  multicycle_controller #(
    .XLEN          (32),
    .FETCH_TIMEOUT (16)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .ctrl_if (ifc)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state kept at instruction granularity.
  int exp_count;
  int exp_alu;
  bit exp_halted, exp_illegal, exp_timeout;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input int st, input bit mreq,
                             input bit irwe, input bit pcen, input bit regwe);
    check_eq({tag, "/state"},   32'(ifc.state), st);
    check_eq({tag, "/mem_req"}, 32'(ifc.mem_req), 32'(mreq));
    check_eq({tag, "/ir_we"},   32'(ifc.ir_we), 32'(irwe));
    check_eq({tag, "/pc_en"},   32'(ifc.pc_en), 32'(pcen));
    check_eq({tag, "/reg_we"},  32'(ifc.reg_we), 32'(regwe));
    check_eq({tag, "/alu_op"},  32'(ifc.alu_op), exp_alu);
    check_eq({tag, "/count"},   ifc.instr_count, exp_count);
    check_eq({tag, "/halted"},  32'(ifc.halted), 32'(exp_halted));
    check_eq({tag, "/illegal"}, 32'(ifc.illegal), 32'(exp_illegal));
    check_eq({tag, "/timeout"}, 32'(ifc.timeout), 32'(exp_timeout));
  endtask

  // Advance to the next falling edge, drive inputs, settle.
  task automatic cyc(input logic rdy, input logic rn);
    @(negedge clock);
    ifc.mem_ready = rdy;
    ifc.run       = rn;
    #1;
  endtask

  // 0 = supported ALU op (op set), 1 = SYSTEM, 2 = illegal.
  function automatic int classify(input logic [31:0] ins, output int op);
    logic [31:0] match [5];
    match[0] = 32'h0000_0033; // ADD
    match[1] = 32'h4000_0033; // SUB
    match[2] = 32'h0000_7033; // AND
    match[3] = 32'h0000_6033; // OR
    match[4] = 32'h0000_4033; // XOR
    op = 0;
    if (ins[6:0] == 7'h73) return 1;
    for (int k = 0; k < 5; k++) begin
      if ((ins & 32'hFE00_707F) == match[k]) begin
        op = k;
        return 0;
      end
    end
    return 2;
  endfunction

  function automatic logic [31:0] make_rtype(input int op, input int rd, input int rs1, input int rs2);
    logic [2:0] f3;
    logic [6:0] f7;
    f7 = (op == 1) ? 7'h20 : 7'h00;
    case (op)
      2:       f3 = 3'b111;
      3:       f3 = 3'b110;
      4:       f3 = 3'b100;
      default: f3 = 3'b000;
    endcase
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    ifc.run = 1'b0;
    ifc.mem_ready = 1'b0;
    #1;
    exp_count = 0; exp_alu = 0;
    exp_halted = 1'b0; exp_illegal = 1'b0; exp_timeout = 1'b0;
    check_cycle("reset", ST_IDLE, 0, 0, 0, 0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    reset = 1'b1;
  endtask

  // Run one instruction through the expected phase sequence.
  task automatic exec_instr(input logic [31:0] ins, input int waits, input logic run_next,
                            input bit from_idle, input bit rst_in_exec);
    int kind, op;
    if (from_idle) begin
      cyc(1'($urandom), 1'b1);
      check_cycle("idle", ST_IDLE, 0, 0, 0, 0);
    end
    for (int w = 0; w < waits; w++) begin
      cyc(1'b0, 1'b1);
      check_cycle("fetch_wait", ST_FETCH, 1, 0, 0, 0);
    end
    cyc(1'b1, 1'b1);
    ifc.instruction = ins;
    check_cycle("fetch", ST_FETCH, 1, 1, 0, 0);
    cyc(1'($urandom), run_next);
    check_cycle("decode", ST_DECODE, 0, 0, 0, 0);
    kind = classify(ins, op);
    if (kind != 0) begin
      exp_halted  = 1'b1;
      exp_illegal = (kind == 2);
      for (int k = 0; k < 3; k++) begin
        cyc(1'($urandom), 1'b1);
        check_cycle("halt", ST_HALT, 0, 0, 0, 0);
      end
      return;
    end
    exp_alu = op;
    cyc(1'($urandom), run_next);
    check_cycle("execute", ST_EXECUTE, 0, 0, 0, 0);
    if (rst_in_exec) begin
      #2 reset = 1'b0;
      #1;
      exp_count = 0; exp_alu = 0;
      check_cycle("async_rst", ST_IDLE, 0, 0, 0, 0);
      cyc(1'b0, 1'b0);
      check_cycle("rst_hold", ST_IDLE, 0, 0, 0, 0);
      reset = 1'b1;
      return;
    end
    cyc(1'($urandom), run_next);
    check_cycle("writeback", ST_WB, 0, 0, 1, ins[11:7] != 5'd0);
    exp_count++;
    if (!run_next) begin
      cyc(1'($urandom), 1'b0);
      check_cycle("park", ST_IDLE, 0, 0, 0, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    bit prev_idle;
    ifc.run = 1'b0;
    ifc.mem_ready = 1'b0;
    ifc.instruction = 32'd0;
    do_reset();

    // Three back-to-back ADD x1,x2,x3 with memory always ready.
    exec_instr(32'h003100B3, 0, 1'b1, 1'b1, 1'b0);
    exec_instr(32'h003100B3, 0, 1'b1, 1'b0, 1'b0);
    exec_instr(32'h003100B3, 0, 1'b0, 1'b0, 1'b0);
    check_eq("happy_count", ifc.instr_count, 32'd3);

    // Fetch stall, then rd = x0.
    exec_instr(32'h003100B3, 5, 1'b1, 1'b1, 1'b0);
    exec_instr(32'h00208033, 0, 1'b0, 1'b0, 1'b0);

    // Random legal instruction stream with random stalls and run gaps.
    prev_idle = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ins;
      logic rn;
      ins = make_rtype($urandom_range(0, 4), $urandom_range(0, 31),
                       $urandom_range(0, 31), $urandom_range(0, 31));
      rn  = ($urandom_range(0, 3) != 0);
      exec_instr(ins, $urandom_range(0, 3), rn, prev_idle, 1'b0);
      prev_idle = !rn;
    end

`ifndef CTRL_FETCH_TIMEOUT_EN
    // Without the timeout option a long stall is simply waited out.
    exec_instr(32'h0020C1B3, 20, 1'b0, prev_idle, 1'b0);
    prev_idle = 1'b1;
`endif

    // Asynchronous reset in the middle of EXECUTE.
    exec_instr(32'h40208133, 1, 1'b1, prev_idle, 1'b1);

    // Illegal all-zeros word, then ebreak.
    exec_instr(32'h00000000, 0, 1'b1, 1'b1, 1'b0);
    do_reset();
    exec_instr(32'h00100073, 2, 1'b1, 1'b1, 1'b0);
    do_reset();

`ifdef CTRL_FETCH_TIMEOUT_EN
    // mem_ready never arrives: HALT with timeout after 16 FETCH cycles.
    cyc(1'b0, 1'b1);
    check_cycle("to_idle", ST_IDLE, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 1'b1);
      check_cycle("to_fetch", ST_FETCH, 1, 0, 0, 0);
    end
    cyc(1'b0, 1'b1);
    exp_halted = 1'b1;
    exp_timeout = 1'b1;
    check_cycle("to_halt", ST_HALT, 0, 0, 0, 0);
    do_reset();
    // mem_ready in the 16th FETCH cycle is still accepted.
    exec_instr(32'h003100B3, 15, 1'b0, 1'b1, 1'b0);
    check_eq("to_last_cycle_count", ifc.instr_count, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
